rr_arbiter8_decoded: RTL and testbench

//   Round-robin arbiter sharing one resource among 8 requesters. Selects a

---
 rtl/rr_arbiter8_decoded.sv | 119 +++++++++++
 tb/tb_rr_arbiter8_decoded.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8_decoded.sv
// Round-robin arbiter for 8 requesters.
// The owner keeps the grant while it requests. Under contention it keeps the
// grant for at most MAX_HOLD consecutive cycles. The winner index is decoded
// to a one-hot grant, and that decode is also registered.
module rr_arbiter8_decoded #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nxt;
    logic [2:0]       ptr, ptr_nxt;
    logic [2:0]       idx_nxt;
    logic             valid_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic [7:0]       gnt_nxt;
    logic [7:0]       others;
    logic             owner_req;
    logic [3:0]       pick_req;
    logic [3:0]       pick_oth;

    // Returns {found, index} for the first set bit of mask, searching
    // start, start+1, ... and wrapping from 7 back to 0.
    // The loop runs from the highest offset down, so the nearest match is
    // written last and wins.
    function automatic logic [3:0] pick(input logic [7:0] mask, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] pos;
        res = '0;
        for (int i = 7; i >= 0; i--) begin
            pos = start + 3'(i);
            if (mask[pos]) res = {1'b1, pos};
        end
        return res;
    endfunction

    assign owner_req = req[gnt_idx];
    assign others    = req & ~(8'b1 << gnt_idx);
    assign pick_req  = pick(req, ptr);
    assign pick_oth  = pick(others, gnt_idx + 3'd1);

    // Next-state logic: arbitration, release, preemption and hold counting.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = gnt_idx;
        valid_nxt = gnt_valid;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (pick_req[3]) begin
                    state_nxt = GRANT;
                    idx_nxt   = pick_req[2:0];
                    valid_nxt = 1'b1;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                // Release and preemption both hand over, starting the search
                // just past the current owner.
                if (!owner_req || (pick_oth[3] && hold_cnt == HOLD_LAST)) begin
                    ptr_nxt  = gnt_idx + 3'd1;
                    hold_nxt = '0;
                    if (pick_oth[3]) begin
                        idx_nxt = pick_oth[2:0];
                    end else begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        idx_nxt   = '0;
                    end
                end else begin
                    // An owner with no competition may hold indefinitely.
                    hold_nxt = pick_oth[3] ? hold_cnt + 1'b1 : '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                idx_nxt   = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    // Decode the next owner index to one-hot, gated by grant-valid.
    always_comb begin
        gnt_nxt = valid_nxt ? (8'b1 << idx_nxt) : 8'b0;
    end

    // State, pointer, hold counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            gnt       <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            gnt       <= gnt_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8_decoded.sv
// Self-checking bench for rr_arbiter8_decoded.
// It runs directed scenarios and then randomized traffic. Every output is
// compared with a behavioural model of the round-robin rules.
module tb_rr_arbiter8_decoded;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int checks = 0;
    int errors = 0;

    // Model state: owner (-1 when idle), round-robin start, and the number
    // of consecutive contended cycles the current owner has held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_run   = 0;

    rr_arbiter8_decoded #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] m, input int start);
        for (int i = 0; i < 8; i++) begin
            if (m[(start + i) % 8]) return (start + i) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_run   = 0;
    endtask

    task automatic model_edge(input logic [7:0] r);
        logic [7:0] others;
        int k;
        if (m_owner < 0) begin
            if (r != 0) begin
                m_owner = pick(r, m_ptr);
                m_run   = 0;
            end
        end else begin
            k = m_owner;
            others = r;
            others[k] = 1'b0;
            if (!r[k] || (others != 0 && m_run == MAX_HOLD - 1)) begin
                m_ptr   = (k + 1) % 8;
                m_owner = (others != 0) ? pick(others, m_ptr) : -1;
                m_run   = 0;
            end else begin
                m_run = (others != 0) ? m_run + 1 : 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] eg;
        eg = (m_owner >= 0) ? (8'b1 << m_owner) : 8'b0;
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".idx"}, 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk({tag, ".valid"}, 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    endtask

    // Apply r, wait for one clock edge, advance the model, and compare 1 ns
    // after the edge.
    task automatic step(input logic [7:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_model(tag);
    endtask

    task automatic sync_reset_all();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    // Pulse reset between clock edges; the outputs must clear right away.
    task automatic async_pulse(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_model(tag);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r;

        // Reset with every requester active, then stay idle.
        req = 8'hFF;
        #2 rst = 1'b1;
        #2;
        chk("rst.gnt", 32'(gnt), 32'h0);
        chk("rst.idx", 32'(gnt_idx), 32'h0);
        chk("rst.valid", 32'(gnt_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold.gnt", 32'(gnt), 32'h0);
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(8'h00, "idle");

        // Single requester: grant, then release.
        step(8'h20, "single");
        chk("single.gnt", 32'(gnt), 32'h20);
        chk("single.idx", 32'(gnt_idx), 32'd5);
        step(8'h20, "single");
        step(8'h20, "single");
        step(8'h00, "single_rel");
        chk("single_rel.gnt", 32'(gnt), 32'h0);
        chk("single_rel.valid", 32'(gnt_valid), 32'h0);

        // All requesting from reset: each owner holds for exactly MAX_HOLD
        // cycles, and ownership wraps from 7 to 0.
        sync_reset_all();
        for (int c = 0; c < 33; c++) begin
            step(8'hFF, "full");
            chk("full.rot_idx", 32'(gnt_idx), 32'((c / MAX_HOLD) % 8));
        end

        // Back-to-back hand-over with no idle cycle.
        sync_reset_all();
        step(8'h04, "b2b");
        chk("b2b.own2", 32'(gnt_idx), 32'd2);
        step(8'h46, "b2b");
        chk("b2b.keep2", 32'(gnt), 32'h04);
        step(8'h42, "b2b");
        chk("b2b.to6.gnt", 32'(gnt), 32'h40);
        chk("b2b.to6.idx", 32'(gnt_idx), 32'd6);
        step(8'h02, "b2b");
        chk("b2b.to1.gnt", 32'(gnt), 32'h02);
        chk("b2b.to1.idx", 32'(gnt_idx), 32'd1);

        // An uncontended owner is never dropped.
        step(8'h00, "gap");
        for (int i = 0; i < 20; i++) begin
            step(8'h08, "lone");
            chk("lone.gnt", 32'(gnt), 32'h08);
        end

        // Asynchronous reset while owner 4 holds the grant.
        step(8'h00, "gap");
        step(8'h10, "ar");
        chk("ar.own4", 32'(gnt_idx), 32'd4);
        step(8'h10, "ar");
        async_pulse("ar_async");
        step(8'h30, "ar_after");
        chk("ar_after.idx", 32'(gnt_idx), 32'd4);
        step(8'h20, "ar_rel");
        chk("ar_rel.idx", 32'(gnt_idx), 32'd5);

        // Randomized traffic with occasional reset pulses.
        r = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 5))
                0: r = 8'($urandom) & 8'($urandom);
                1: r = 8'($urandom);
                2: r[$urandom_range(0, 7)] = ~r[$urandom_range(0, 7)];
                3: r[gnt_idx] = 1'b0;
                default: ;
            endcase
            step(r, "rand");
            if ($urandom_range(0, 249) == 0) async_pulse("rand_async");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
